imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Pipelined, parametrised immediate extractor/extender for the LEGv8 datapath. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes its format (R, I, D, IW, CB, B). It produces the extended immediate at DATA_W bits, with optional word-scaling of branch offsets, two cycles later. It sits between the IF/ID instruction register and the ID/EX operand mux, supports backpressure and a pipeline flush, and carries a sideband tag so the consumer can match results to instructions.

## Interface
- INST_W, 32, instruction width; only 32 is supported.
- DATA_W, 64, output width; must be ≥ 32.
- TAG_W, 4, sideband tag width; must be ≥ 1.
- BR_SHIFT, 0: when 1, CB and B offsets are multiplied by 4 after sign extension.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; invalidates both stages.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept this cycle.
- inst  in  INST_W  instruction word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- ex_data  out  DATA_W  extended immediate.
- fmt  out  3  format code: 0 R/pass, 1 I, 2 D, 3 IW, 4 CB, 5 B; 6–7 unused.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Decode priority, first match wins:
  - B: inst[31:26] ∈ {6'h05, 6'h25}
  - CB: inst[31:24] ∈ {8'hB4, 8'hB5}
  - D: inst[31:21] ∈ {11'h7C0, 11'h7C2}
  - IW: inst[31:23] ∈ {9'h1A5, 9'h1E5}
  - I: inst[31:22] ∈ {10'h244, 10'h344, 10'h248, 10'h2C4}
  - otherwise R.
- Extraction:
  - D: sign-extend inst[20:12] (9 bits).
  - CB: sign-extend inst[23:5] (19 bits).
  - B: sign-extend inst[25:0] (26 bits).
  - I: zero-extend inst[21:10] (12 bits).
  - IW: zero-extend inst[20:5], then shift left by 16·inst[22:21].
  - R: zero-extend inst.
- BR_SHIFT=1: CB and B results are shifted left by 2 at full DATA_W. No other format is affected.
- Width rule: every result is computed at DATA_W. Bits shifted above DATA_W are discarded. Example: IW with hw=2 or 3 at DATA_W=32 yields 0.
- Stage 1 (S1) registers inst, tag and fmt. Stage 2 (S2) registers ex_data, fmt and tag. The S2 registers drive the outputs directly.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv & !flush
- A transfer happens only when valid and ready are both high. Data and tag registers load only on an advancing valid.
- Order is strictly preserved. No result is dropped or duplicated under backpressure.
- flush: at the next edge, s1_valid and s2_valid become 0. An instruction presented in the flush cycle is not accepted. Data registers keep their values.

## Timing
- Reset (async assert) clears s1_valid, s2_valid, ex_data, fmt and out_tag to 0. out_valid is 0 during and after reset.
- in_ready is 1 after reset release while flush is low.
- Latency: an instruction accepted at edge N appears on out_valid/ex_data after edge N+1, provided out_ready was high. Full throughput is one result per cycle.
- While out_ready is low, outputs hold stable. Up to 2 instructions are buffered; in_ready drops once S1 and S2 are both full.
- Simultaneous out_ready=1 with a full pipe: S2 takes S1 and S1 takes the input in the same edge.
- Reset asserted mid-operation discards all in-flight results immediately; no partial output is produced.
- Flush and out_ready in the same cycle: the S2 result counts as consumed if out_valid was high. It is not re-presented.

## Test plan
- DATA_W=64, BR_SHIFT=0, out_ready=1:
  - 0xF84402C9 tag 1 → ex_data 64, fmt 2, tag 1, two cycles after acceptance.
  - 0xB4FFFF6B → 0xFFFFFFFFFFFFFFFB, fmt 4.
  - 0x8B09026A → 0x8B09026A, fmt 0.
- I and IW formats:
  - 0x913FFD49 (ADDI #4095) → 0xFFF, fmt 1.
  - 0xD2A24689 (MOVZ #0x1234, LSL 16) → 0x12340000, fmt 3.
  - At DATA_W=32, 0xD2E24689 (hw=3) → 0.
- BR_SHIFT=1:
  - 0x17FFFFC9 → 0xFFFFFFFFFFFFFF24 (−220), fmt 5.
  - 0x14000040 → 256.
- Backpressure: hold out_ready=0 and stream 3 instructions with tags 1, 2, 3.
  - in_ready must fall after 2 are accepted; the third waits.
  - Release out_ready: tags 1, 2, 3 emerge in consecutive cycles with correct data.
- Flush with 2 in flight:
  - out_valid=0 at the next cycle.
  - Input presented during the flush cycle is not accepted.
  - The next instruction yields a result with 2-cycle latency.
- Async reset mid-stream: out_valid falls without a clock edge. After release, in_ready=1 and the first new result is correct.

Source files
------------

// File: rtl/imm_ext_if.sv
// imm_ext_if: request/response bundle for imm_ext_pipe.
//   slave  : the extractor (consumes in_*, out_ready; drives in_ready, out_*)
//   master : the producer/consumer side (IF/ID register and ID/EX mux)
// Signals:
//   in_valid/in_ready  instruction handshake
//   inst, in_tag       instruction word and sideband tag
//   out_valid/out_ready result handshake
//   ex_data, fmt, out_tag  extended immediate, format code, matching tag
interface imm_ext_if #(
  parameter int INST_W = 32,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [INST_W-1:0] inst;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ex_data;
  logic [2:0]        fmt;
  logic [TAG_W-1:0]  out_tag;

  modport slave (
    input  in_valid, inst, in_tag, out_ready,
    output in_ready, out_valid, ex_data, fmt, out_tag
  );

  modport master (
    output in_valid, inst, in_tag, out_ready,
    input  in_ready, out_valid, ex_data, fmt, out_tag
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: two-stage LEGv8 immediate extractor/extender.
//   S1 latches the instruction, its tag and the decoded format.
//   S2 latches the extended immediate, format and tag; S2 drives the outputs.
// Ports:
//   clk    rising-edge clock
//   rst_n  async active-low reset
//   flush  sync; drops both stages, input is refused that cycle
//   bus    imm_ext_if.slave (in_valid/in_ready/inst/in_tag,
//          out_valid/out_ready/ex_data/fmt/out_tag)
// Format codes on fmt: 0 R, 1 I, 2 D, 3 IW, 4 CB, 5 B.
module imm_ext_pipe #(
  parameter int INST_W   = 32,
  parameter int DATA_W   = 64,
  parameter int TAG_W    = 4,
  parameter bit BR_SHIFT = 1'b0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      flush,
  imm_ext_if.slave  bus
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_D  = 3'd2;
  localparam logic [2:0] FMT_IW = 3'd3;
  localparam logic [2:0] FMT_CB = 3'd4;
  localparam logic [2:0] FMT_B  = 3'd5;

  // vld_pipe[1] = S1 valid, vld_pipe[2] = S2 valid
  logic [2:1]        vld_pipe;
  logic [INST_W-1:0] s1_inst;
  logic [TAG_W-1:0]  s1_tag;
  logic [2:0]        s1_fmt;
  logic [DATA_W-1:0] s2_data;
  logic [2:0]        s2_fmt;
  logic [TAG_W-1:0]  s2_tag;

  logic       s1_adv, s2_adv;
  logic [2:0] dec_fmt;

  assign s2_adv       = !vld_pipe[2] || bus.out_ready;
  assign s1_adv       = !vld_pipe[1] || s2_adv;
  assign bus.in_ready = s1_adv && !flush;

  // Opcode decode; order matters because the opcode fields overlap.
  always_comb begin
    dec_fmt = FMT_R;
    if (bus.inst[31:26] == 6'h05 || bus.inst[31:26] == 6'h25)
      dec_fmt = FMT_B;
    else if (bus.inst[31:24] == 8'hB4 || bus.inst[31:24] == 8'hB5)
      dec_fmt = FMT_CB;
    else if (bus.inst[31:21] == 11'h7C0 || bus.inst[31:21] == 11'h7C2)
      dec_fmt = FMT_D;
    else if (bus.inst[31:23] == 9'h1A5 || bus.inst[31:23] == 9'h1E5)
      dec_fmt = FMT_IW;
    else if (bus.inst[31:22] == 10'h244 || bus.inst[31:22] == 10'h344 ||
             bus.inst[31:22] == 10'h248 || bus.inst[31:22] == 10'h2C4)
      dec_fmt = FMT_I;
  end

  // Field extraction at DATA_W; anything shifted past DATA_W falls off,
  // so a MOVZ/MOVK with hw=2/3 at DATA_W=32 yields 0.
  logic [DATA_W-1:0] sx_d, sx_cb, sx_b, zx_i, zx_iw, zx_r, ext;

  assign sx_d  = {{(DATA_W-9){s1_inst[20]}},  s1_inst[20:12]};
  assign sx_cb = {{(DATA_W-19){s1_inst[23]}}, s1_inst[23:5]};
  assign sx_b  = {{(DATA_W-26){s1_inst[25]}}, s1_inst[25:0]};
  assign zx_i  = DATA_W'(s1_inst[21:10]);
  assign zx_iw = DATA_W'(s1_inst[20:5]) << {s1_inst[22:21], 4'b0000};
  assign zx_r  = DATA_W'(s1_inst);

  always_comb begin
    ext = zx_r;
    case (s1_fmt)
      FMT_I:   ext = zx_i;
      FMT_D:   ext = sx_d;
      FMT_IW:  ext = zx_iw;
      FMT_CB:  ext = BR_SHIFT ? (sx_cb << 2) : sx_cb;
      FMT_B:   ext = BR_SHIFT ? (sx_b << 2) : sx_b;
      default: ext = zx_r;
    endcase
  end

  // Flush only kills the valid bits; payload registers are left as-is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_inst  <= '0;
      s1_tag   <= '0;
      s1_fmt   <= FMT_R;
      s2_data  <= '0;
      s2_fmt   <= FMT_R;
      s2_tag   <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s2_adv) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          s2_data <= ext;
          s2_fmt  <= s1_fmt;
          s2_tag  <= s1_tag;
        end
      end
      if (s1_adv) begin
        vld_pipe[1] <= bus.in_valid;
        if (bus.in_valid) begin
          s1_inst <= bus.inst;
          s1_tag  <= bus.in_tag;
          s1_fmt  <= dec_fmt;
        end
      end
    end
  end

  assign bus.out_valid = vld_pipe[2];
  assign bus.ex_data   = s2_data;
  assign bus.fmt       = s2_fmt;
  assign bus.out_tag   = s2_tag;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Scoreboard bench for imm_ext_pipe. Three instances share one stimulus:
//   u_a: DATA_W=64 BR_SHIFT=0, u_b: DATA_W=64 BR_SHIFT=1, u_c: DATA_W=32.
// The driver pushes hand-computed expectations on acceptance; a negedge
// monitor pops and compares whenever a result is consumed.
module tb_imm_ext_pipe;

  logic        clk, rst_n, flush;
  logic        in_valid, out_ready;
  logic [31:0] inst;
  logic [3:0]  in_tag;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] d;
    logic [2:0]  f;
    logic [3:0]  t;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  // inst, result @64/BR0, result @64/BR1, result @32, fmt
  logic [31:0] v_inst [15] = '{
    32'hF84402C9, 32'hB4FFFF6B, 32'h8B09026A, 32'h913FFD49, 32'hD2A24689,
    32'hD2E24689, 32'hD2C24689, 32'h17FFFFC9, 32'h14000040, 32'hB5000041,
    32'hF81F83E0, 32'h94000003, 32'hF2A24689, 32'hB1000421, 32'hFFFFFFFF};
  logic [63:0] v_e64 [15] = '{
    64'h40, 64'hFFFFFFFFFFFFFFFB, 64'h8B09026A, 64'hFFF, 64'h12340000,
    64'h1234000000000000, 64'h0000123400000000, 64'hFFFFFFFFFFFFFFC9, 64'h40, 64'h2,
    64'hFFFFFFFFFFFFFFF8, 64'h3, 64'h12340000, 64'h1, 64'hFFFFFFFF};
  logic [63:0] v_ebr [15] = '{
    64'h40, 64'hFFFFFFFFFFFFFFEC, 64'h8B09026A, 64'hFFF, 64'h12340000,
    64'h1234000000000000, 64'h0000123400000000, 64'hFFFFFFFFFFFFFF24, 64'h100, 64'h8,
    64'hFFFFFFFFFFFFFFF8, 64'hC, 64'h12340000, 64'h1, 64'hFFFFFFFF};
  logic [31:0] v_e32 [15] = '{
    32'h40, 32'hFFFFFFFB, 32'h8B09026A, 32'hFFF, 32'h12340000,
    32'h0, 32'h0, 32'hFFFFFFC9, 32'h40, 32'h2,
    32'hFFFFFFF8, 32'h3, 32'h12340000, 32'h1, 32'hFFFFFFFF};
  logic [2:0] v_fmt [15] = '{
    3'd2, 3'd4, 3'd0, 3'd1, 3'd3, 3'd3, 3'd3, 3'd5, 3'd5, 3'd4,
    3'd2, 3'd5, 3'd3, 3'd1, 3'd0};

  imm_ext_if #(.DATA_W(64)) if_a ();
  imm_ext_if #(.DATA_W(64)) if_b ();
  imm_ext_if #(.DATA_W(32)) if_c ();

  assign if_a.in_valid = in_valid;  assign if_a.inst = inst;
  assign if_a.in_tag = in_tag;      assign if_a.out_ready = out_ready;
  assign if_b.in_valid = in_valid;  assign if_b.inst = inst;
  assign if_b.in_tag = in_tag;      assign if_b.out_ready = out_ready;
  assign if_c.in_valid = in_valid;  assign if_c.inst = inst;
  assign if_c.in_tag = in_tag;      assign if_c.out_ready = out_ready;

  imm_ext_pipe #(.DATA_W(64), .BR_SHIFT(1'b0)) u_a (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_a));
  imm_ext_pipe #(.DATA_W(64), .BR_SHIFT(1'b1)) u_b (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_b));
  imm_ext_pipe #(.DATA_W(32), .BR_SHIFT(1'b0)) u_c (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Present vector idx until accepted; returns 1 time unit after the edge.
  task automatic send(input int idx, input logic [3:0] tag);
    bit ok = 1'b0;
    in_valid = 1'b1;
    inst     = v_inst[idx];
    in_tag   = tag;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      if (if_a.in_ready) begin
        ok = 1'b1;
        qa.push_back('{d: v_e64[idx], f: v_fmt[idx], t: tag});
        qb.push_back('{d: v_ebr[idx], f: v_fmt[idx], t: tag});
        qc.push_back('{d: {32'h0, v_e32[idx]}, f: v_fmt[idx], t: tag});
      end
    end
    if (!ok) fail_now("send_timeout", "in_ready stayed 0, want 1");
    else @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Accept into an empty pipe: nothing after edge N, result after edge N+1.
  task automatic send_lat(input int idx, input logic [3:0] tag, input string name);
    send(idx, tag);
    chk({name, "_valid_n"}, 64'(if_a.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk({name, "_valid_n1"}, 64'(if_a.out_valid), 64'd1);
    chk({name, "_tag_n1"}, 64'(if_a.out_tag), 64'(tag));
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 30; c++) begin
      if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk({name, "_left_a"}, 64'(qa.size()), 64'd0);
    chk({name, "_left_b"}, 64'(qb.size()), 64'd0);
    chk({name, "_left_c"}, 64'(qc.size()), 64'd0);
  endtask

  task automatic clear_q();
    qa.delete();
    qb.delete();
    qc.delete();
  endtask

  // Monitor: a result is consumed at the next edge when out_valid & out_ready.
  always @(negedge clk) begin
    if (rst_n && out_ready && !flush) begin
      if (if_a.out_valid) begin
        if (qa.size() == 0) fail_now("a_unexpected", $sformatf("tag %0d with empty queue", if_a.out_tag));
        else begin
          ea = qa.pop_front();
          chk("a_data", if_a.ex_data, ea.d);
          chk("a_fmt", 64'(if_a.fmt), 64'(ea.f));
          chk("a_tag", 64'(if_a.out_tag), 64'(ea.t));
        end
      end
      if (if_b.out_valid) begin
        if (qb.size() == 0) fail_now("b_unexpected", $sformatf("tag %0d with empty queue", if_b.out_tag));
        else begin
          eb = qb.pop_front();
          chk("b_data", if_b.ex_data, eb.d);
          chk("b_fmt", 64'(if_b.fmt), 64'(eb.f));
        end
      end
      if (if_c.out_valid) begin
        if (qc.size() == 0) fail_now("c_unexpected", $sformatf("tag %0d with empty queue", if_c.out_tag));
        else begin
          ec = qc.pop_front();
          chk("c_data", 64'(if_c.ex_data), ec.d);
          chk("c_tag", 64'(if_c.out_tag), 64'(ec.t));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inst = '0; in_tag = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 64'(if_a.out_valid), 64'd0);
    chk("rst_ex_data", if_a.ex_data, 64'd0);
    chk("rst_fmt", 64'(if_a.fmt), 64'd0);
    chk("rst_out_tag", 64'(if_a.out_tag), 64'd0);
    chk("rst_c_valid", 64'(if_c.out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(if_a.in_ready), 64'd1);

    // First vector with latency check, then a back-to-back stream
    out_ready = 1'b1;
    send_lat(0, 4'd1, "lat0");
    for (int i = 1; i < 15; i++) send(i, 4'(i));
    drain("stream");

    // Backpressure: two buffered, third waits until out_ready returns
    out_ready = 1'b0;
    send(10, 4'd1);
    send(11, 4'd2);
    in_valid = 1'b1; inst = v_inst[12]; in_tag = 4'd3;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(if_a.in_ready), 64'd0);
      chk("bp_hold_valid", 64'(if_a.out_valid), 64'd1);
      chk("bp_hold_tag", 64'(if_a.out_tag), 64'd1);
      chk("bp_hold_data", if_a.ex_data, 64'hFFFFFFFFFFFFFFF8);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    fork
      send(12, 4'd3);
      begin
        for (int k = 1; k <= 3; k++) begin
          @(negedge clk);
          chk("bp_consec_valid", 64'(if_a.out_valid), 64'd1);
          chk("bp_consec_tag", 64'(if_a.out_tag), 64'(k));
        end
      end
    join
    drain("bp");

    // Flush with two in flight; input offered in the flush cycle is refused
    out_ready = 1'b0;
    send(2, 4'd5);
    send(3, 4'd6);
    flush = 1'b1; in_valid = 1'b1; inst = v_inst[4]; in_tag = 4'd7;
    @(negedge clk);
    chk("flush_in_ready", 64'(if_a.in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    clear_q();
    chk("flush_out_valid", 64'(if_a.out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_stays_empty", 64'(if_a.out_valid), 64'd0);
    send_lat(4, 4'd8, "flush_lat");
    drain("flush");

    // Async reset mid-stream: outputs drop without a clock edge
    out_ready = 1'b0;
    send(7, 4'd9);
    send(8, 4'd10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_a_valid", 64'(if_a.out_valid), 64'd0);
    chk("arst_b_valid", 64'(if_b.out_valid), 64'd0);
    chk("arst_ex_data", if_a.ex_data, 64'd0);
    clear_q();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("arst_in_ready", 64'(if_a.in_ready), 64'd1);
    out_ready = 1'b1;
    send_lat(7, 4'd11, "arst_lat");
    drain("arst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
